// File: rtl/arb_req_ctrl.sv
// Requester front-end for a combinational fixed-priority arbiter (port 0 highest).
// Each port runs a burst of len+1 beats, holding req_o until the last granted beat,
// then drops req_o for one cool-down cycle before it can accept a new start.
// Optional grant-starvation abort is built only when ARB_REQ_TIMEOUT_EN is defined;
// otherwise timeout_o is tied low and a starved port keeps requesting.
module arb_req_ctrl #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_PORTS-1:0]       start_i,
  input  logic [NUM_PORTS*LEN_W-1:0] len_i,
  output logic [NUM_PORTS-1:0]       req_o,
  input  logic [NUM_PORTS-1:0]       gnt_i,
  output logic [NUM_PORTS-1:0]       beat_o,
  output logic [NUM_PORTS-1:0]       done_o,
  output logic [NUM_PORTS-1:0]       busy_o,
  output logic [NUM_PORTS-1:0]       timeout_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StCool   = 2'd2
  } state_e;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             beat;
    logic             starve;

    // req_o is a pure function of the registered state, so it is glitch-free
    // toward the arbiter even though the grant loop closes in the same cycle.
    assign beat = (state_q == StActive) & gnt_i[p];

`ifdef ARB_REQ_TIMEOUT_EN
    localparam logic [15:0] Limit = 16'(TIMEOUT_CYC);

    logic [15:0] wait_q, wait_d;
    logic        timeout_q, timeout_d;

    // A grant in the limit cycle takes precedence: starve requires no grant.
    assign starve = (state_q == StActive) & ~gnt_i[p] & ((wait_q + 16'd1) == Limit);

    // Starvation counter: cleared on burst entry and on every beat.
    always_comb begin
      wait_d    = wait_q;
      timeout_d = 1'b0;
      if (state_q == StIdle) begin
        if (start_i[p]) wait_d = '0;
      end else if (state_q == StActive) begin
        if (beat) begin
          wait_d = '0;
        end else if (starve) begin
          wait_d    = '0;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
    end

    // Counter and timeout pulse registers; the pulse lands in the COOL cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wait_q    <= '0;
        timeout_q <= 1'b0;
      end else begin
        wait_q    <= wait_d;
        timeout_q <= timeout_d;
      end
    end

    assign timeout_o[p] = timeout_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign starve             = 1'b0;
    assign timeout_o[p]       = 1'b0;
`endif

    // Next-state and remaining-beat logic for one port.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      unique case (state_q)
        StIdle: begin
          if (start_i[p]) begin
            state_d = StActive;
            rem_d   = len_i[p*LEN_W +: LEN_W];
          end
        end
        StActive: begin
          if (beat) begin
            if (rem_q == '0) state_d = StCool;
            else             rem_d   = rem_q - LEN_W'(1);
          end else if (starve) begin
            state_d = StCool;
            rem_d   = '0;
          end
        end
        StCool:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // State and remaining-beat registers; reset drops any burst in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= StIdle;
        rem_q   <= '0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
      end
    end

    assign req_o[p]  = (state_q == StActive);
    assign beat_o[p] = beat;
    assign done_o[p] = beat & (rem_q == '0);
    assign busy_o[p] = (state_q != StIdle);
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Self-checking bench for arb_req_ctrl. A fixed-priority arbiter model closes the
// req/gnt loop; expected beats are queued as bursts are started and matched
// against beat_o/done_o as they appear. Timeout scenarios depend on ARB_REQ_TIMEOUT_EN.
module tb_arb_req_ctrl;
  localparam int NP = 4;
  localparam int LW = 4;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam int GntAt = 16;  // grant arrives in the cycle the counter would hit the limit
`else
  localparam int GntAt = 40;  // no limit: port must still be requesting here
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [NP-1:0]  start_i;
  logic [NP*LW-1:0] len_i;
  logic [NP-1:0]  req_o, gnt_i, beat_o, done_o, busy_o, timeout_o;
  logic           gnt_ovr_en;
  logic [NP-1:0]  gnt_ovr;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_v;

  always #5 clk_i = ~clk_i;

  // Fixed-priority arbiter, port 0 highest; override lets a test shape the grant.
  always_comb begin
    gnt_i = '0;
    if (gnt_ovr_en) begin
      gnt_i = gnt_ovr;
    end else begin
      for (int p = NP - 1; p >= 0; p--) begin
        if (req_o[p]) begin
          gnt_i    = '0;
          gnt_i[p] = 1'b1;
        end
      end
    end
  end

  arb_req_ctrl #(
    .NUM_PORTS  (NP),
    .LEN_W      (LW),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .len_i    (len_i),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .beat_o   (beat_o),
    .done_o   (done_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  // Beat record: relative cycle, port, last-beat flag.
  function automatic int key(input int c, input int p, input logic last);
    return c * 64 + p * 2 + ((last === 1'b1) ? 1 : 0);
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni     = 1'b0;
    start_i    = '0;
    len_i      = '0;
    gnt_ovr_en = 1'b1;
    gnt_ovr    = '1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({req_o, busy_o, timeout_o, beat_o, done_o} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got req=%b busy=%b to=%b beat=%b done=%b required all 0",
               req_o, busy_o, timeout_o, beat_o, done_o);
    end
    next_cycle();
    rst_ni     = 1'b1;
    gnt_ovr_en = 1'b0;
    gnt_ovr    = '0;
    @(negedge clk_i);
    checks++;
    if ({req_o, busy_o} !== '0) begin
      errors++;
      $display("FAIL reset release idle: got req=%b busy=%b required 0", req_o, busy_o);
    end
    next_cycle();
  endtask

  task automatic test_single();
    exp_q.delete();
    for (int c = 1; c <= 4; c++) exp_q.push_back(key(c, 2, c == 4));
    for (int c = 0; c < 8; c++) begin
      start_i = (c == 0) ? 4'b0100 : 4'b0000;
      len_i   = (c == 0) ? 16'h0300 : 16'hFFFF;  // later values must not be captured
      @(negedge clk_i);
      checks++;
      if (req_o[2] !== (c >= 1 && c <= 4)) begin
        errors++;
        $display("FAIL single req c%0d: got %b required %b", c, req_o[2], (c >= 1 && c <= 4));
      end
      checks++;
      if (busy_o[2] !== (c >= 1 && c <= 5)) begin
        errors++;
        $display("FAIL single busy c%0d: got %b required %b", c, busy_o[2], (c >= 1 && c <= 5));
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL single beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_preempt();
    exp_q.delete();
    exp_q.push_back(key(1, 3, 1'b0));
    exp_q.push_back(key(2, 0, 1'b0));
    exp_q.push_back(key(3, 0, 1'b1));
    exp_q.push_back(key(4, 3, 1'b0));
    exp_q.push_back(key(5, 3, 1'b0));
    exp_q.push_back(key(6, 3, 1'b1));
    for (int c = 0; c < 9; c++) begin
      start_i = (c == 0) ? 4'b1000 : (c == 1) ? 4'b0001 : 4'b0000;
      len_i   = (c == 0) ? 16'h3000 : 16'h0001;
      @(negedge clk_i);
      checks++;
      if (req_o[3] !== (c >= 1 && c <= 6)) begin
        errors++;
        $display("FAIL preempt req3 c%0d: got %b required %b", c, req_o[3], (c >= 1 && c <= 6));
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL preempt beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL preempt missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete();
    for (int c = 1; c <= 10; c += 3) exp_q.push_back(key(c, 1, 1'b1));
    len_i = '0;
    for (int c = 0; c < 13; c++) begin
      start_i = (c < 10) ? 4'b0010 : 4'b0000;
      @(negedge clk_i);
      checks++;
      if (req_o[1] !== (c % 3 == 1)) begin
        errors++;
        $display("FAIL b2b req1 c%0d: got %b required %b", c, req_o[1], (c % 3 == 1));
      end
      checks++;
      if (busy_o[1] !== (c % 3 != 0)) begin
        errors++;
        $display("FAIL b2b busy1 c%0d: got %b required %b", c, busy_o[1], (c % 3 != 0));
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL b2b beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_max_len();
    exp_q.delete();
    for (int c = 1; c <= 16; c++) exp_q.push_back(key(c, 0, c == 16));
    for (int c = 0; c < 19; c++) begin
      start_i = (c == 0) ? 4'b0001 : 4'b0000;
      len_i   = 16'h000F;
      @(negedge clk_i);
      checks++;
      if (req_o[0] !== (c >= 1 && c <= 16)) begin
        errors++;
        $display("FAIL maxlen req0 c%0d: got %b required %b", c, req_o[0], (c >= 1 && c <= 16));
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL maxlen beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL maxlen missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    exp_q.push_back(key(1, 1, 1'b0));
    exp_q.push_back(key(2, 1, 1'b0));
    for (int c = 0; c < 10; c++) begin
      start_i = (c == 0) ? 4'b0010 : 4'b0000;
      len_i   = 16'h0050;
      if (c == 4) begin
        rst_ni     = 1'b1;
        gnt_ovr_en = 1'b1;  // grants with no request must not produce beats
        gnt_ovr    = '1;
      end
      @(negedge clk_i);
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL rstmid beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      if (c == 2) begin
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_o, busy_o, timeout_o} !== '0) begin
          errors++;
          $display("FAIL rstmid async: got req=%b busy=%b to=%b required 0",
                   req_o, busy_o, timeout_o);
        end
      end
      if (c >= 4) begin
        checks++;
        if ({req_o, busy_o} !== '0) begin
          errors++;
          $display("FAIL rstmid after release c%0d: got req=%b busy=%b required 0",
                   c, req_o, busy_o);
        end
      end
      next_cycle();
    end
    gnt_ovr_en = 1'b0;
    gnt_ovr    = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

  // Grant withheld until GntAt: with the limit, the grant wins exactly at the edge;
  // without it, the port simply waits.
  task automatic test_late_grant();
    exp_q.delete();
    exp_q.push_back(key(GntAt, 2, 1'b1));
    gnt_ovr_en = 1'b1;
    for (int c = 0; c < GntAt + 4; c++) begin
      start_i = (c == 0) ? 4'b0100 : 4'b0000;
      len_i   = '0;
      gnt_ovr = (c == GntAt) ? 4'b0100 : 4'b0000;
      @(negedge clk_i);
      checks++;
      if (req_o[2] !== (c >= 1 && c <= GntAt)) begin
        errors++;
        $display("FAIL lategnt req2 c%0d: got %b required %b", c, req_o[2],
                 (c >= 1 && c <= GntAt));
      end
      checks++;
      if (timeout_o !== '0) begin
        errors++;
        $display("FAIL lategnt timeout c%0d: got %b required 0000", c, timeout_o);
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL lategnt beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    gnt_ovr_en = 1'b0;
    gnt_ovr    = '0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lategnt missing beats: got %0d left required 0", exp_q.size());
    end
  endtask

`ifdef ARB_REQ_TIMEOUT_EN
  task automatic test_timeout();
    exp_q.delete();
    for (int c = 1; c <= 16; c++) exp_q.push_back(key(c, 0, c == 16));
    for (int c = 0; c < 20; c++) begin
      start_i = (c == 0) ? 4'b0011 : 4'b0000;
      len_i   = 16'h003F;
      @(negedge clk_i);
      checks++;
      if (timeout_o !== ((c == 17) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL timeout pulse c%0d: got %b required %b", c, timeout_o,
                 (c == 17) ? 4'b0010 : 4'b0000);
      end
      checks++;
      if (req_o[1] !== (c >= 1 && c <= 16)) begin
        errors++;
        $display("FAIL timeout req1 c%0d: got %b required %b", c, req_o[1],
                 (c >= 1 && c <= 16));
      end
      checks++;
      if (busy_o[1] !== (c >= 1 && c <= 17)) begin
        errors++;
        $display("FAIL timeout busy1 c%0d: got %b required %b", c, busy_o[1],
                 (c >= 1 && c <= 17));
      end
      for (int p = 0; p < NP; p++) if (beat_o[p] === 1'b1) begin
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
        checks++;
        if (key(c, p, done_o[p]) !== exp_v) begin
          errors++;
          $display("FAIL timeout beat: got c%0d p%0d last=%b key %0d required key %0d",
                   c, p, done_o[p], key(c, p, done_o[p]), exp_v);
        end
      end
      next_cycle();
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout missing beats: got %0d left required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_late_grant();
`ifdef ARB_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
